axi_burst_writer: RTL

- Downstream consumer of the write-data FIFO. Takes a burst command (start address, beat count) and drains that many beats from the FIFO's valid/ready output.
- Issues one AXI4 INCR write burst per command on the AW, W and B channels, then reports completion and response status.
- Sits between the write-data FIFO and the AXI memory slave. One outstanding burst at a time.

---
 rtl/axi_burst_writer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axi_burst_writer.sv
// rtl/axi_burst_writer.sv - drains FIFO beats into one AXI4 INCR write burst per command
module axi_burst_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_val,
  output logic                    cmd_rdy,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    done,
  output logic                    err
);

  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_REJECT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [7:0]              r_awlen;
  logic [8:0]              r_cnt;
  logic                    r_wvalid;
  logic                    r_wlast;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_done;
  logic                    r_err;
  logic [31:0]             w_end;
  logic                    w_reject;
  logic                    w_pop;
  logic                    w_wxfer;

  // End offset of the burst within its 4 KB page; beyond 4096 the burst would cross it.
  assign w_end    = {20'd0, cmd_addr[11:0]} + ({24'd0, cmd_len} + 32'd1) * 32'(BYTES);
  assign w_reject = ({24'd0, cmd_len} > 32'(MAX_BURST - 1)) || (w_end > 32'd4096);
  assign w_pop    = in_val && in_rdy;
  assign w_wxfer  = r_wvalid && wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cmd_val) w_next = w_reject ? S_REJECT : S_ADDR;
      S_ADDR:   if (awready) w_next = S_DATA;
      S_DATA:   if (w_wxfer && r_wlast) w_next = S_RESP;
      S_RESP:   if (bvalid) w_next = S_IDLE;
      S_REJECT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy = 1'b0;
    awvalid = 1'b0;
    in_rdy  = 1'b0;
    bready  = 1'b0;
    case (r_state)
      S_IDLE: cmd_rdy = 1'b1;
      S_ADDR: awvalid = 1'b1;
      // Pop only while beats remain and the W register is free or draining this cycle.
      S_DATA: in_rdy  = ({1'b0, r_awlen} >= r_cnt) && (!r_wvalid || wready);
      S_RESP: bready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_cnt    <= '0;
      r_wvalid <= 1'b0;
      r_wlast  <= 1'b0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE && cmd_val) begin
        r_awaddr <= cmd_addr;
        r_awlen  <= cmd_len;
        r_cnt    <= '0;
        if (w_reject) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
      end
      if (w_pop) begin
        r_wvalid <= 1'b1;
        r_wdata  <= in_data;
        r_wlast  <= (r_cnt == {1'b0, r_awlen});
        r_cnt    <= r_cnt + 9'd1;
      end else if (w_wxfer) begin
        r_wvalid <= 1'b0;
        r_wlast  <= 1'b0;
      end
      if (r_state == S_RESP && bvalid) begin
        r_done <= 1'b1;
        r_err  <= (bresp != 2'b00);
      end
    end
  end

  assign awaddr  = r_awaddr;
  assign awlen   = r_awlen;
  assign awsize  = 3'($clog2(BYTES));
  assign awburst = 2'b01;
  assign wdata   = r_wdata;
  assign wstrb   = '1;
  assign wlast   = r_wlast;
  assign wvalid  = r_wvalid;
  assign done    = r_done;
  assign err     = r_err;

endmodule
